// File: rtl/mem_responder_if.sv
// mem_responder_if: processor-side bus of the wait-state memory responder.
//   mem_read / mem_write : request strobes (master -> slave)
//   addr                 : byte address (master -> slave)
//   wdata                : write data (master -> slave)
//   rdata                : read data, valid with ready on a read (slave -> master)
//   ready                : one-cycle response strobe (slave -> master)
//   err                  : error flag, valid with ready (slave -> master)
//   busy                 : request in progress (slave -> master)
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output mem_read, mem_write, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  mem_read, mem_write, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory with a fixed number of wait states.
// A request is accepted on an IDLE clock edge, the responder waits
// WAIT_CYCLES edges, then pulses ready for one cycle (RESP). Misaligned,
// out-of-range and simultaneous read+write requests complete with err=1.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (memory contents are kept)
//   bus  : mem_responder_if.slave (request in, rdata/ready/err/busy out)
// Parameters:
//   DEPTH       : memory size in 32-bit words (power of two, 16..65536)
//   WAIT_CYCLES : wait states per access (0..15)
module mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_next;
  logic [3:0]     cnt, cnt_next;

  // Request captured at the acceptance edge.
  logic           req_write;
  logic           req_err;
  logic [AW-1:0]  req_idx;
  logic [31:0]    req_wdata;

  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH];

  // Live request decode, only meaningful in IDLE.
  logic           live_any;
  logic           live_err;
  logic [AW-1:0]  live_idx;

  // Request that completes on the edge entering RESP. With zero wait
  // states that edge is the acceptance edge itself, so the live inputs
  // must be used instead of the captured copy.
  logic           cur_write;
  logic           cur_err;
  logic [AW-1:0]  cur_idx;
  logic [31:0]    cur_wdata;
  logic           enter_resp;

  assign live_any = bus.mem_read | bus.mem_write;
  assign live_idx = bus.addr[AW+1:2];
  assign live_err = (bus.addr[1:0] != 2'b00)
                 || (bus.addr[31:2] >= 30'(DEPTH))
                 || (bus.mem_read && bus.mem_write);

  assign cur_write = (state == S_IDLE) ? bus.mem_write : req_write;
  assign cur_err   = (state == S_IDLE) ? live_err      : req_err;
  assign cur_idx   = (state == S_IDLE) ? live_idx      : req_idx;
  assign cur_wdata = (state == S_IDLE) ? bus.wdata     : req_wdata;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (live_any) begin
          if (WAIT_CYCLES == 0) begin
            state_next = S_RESP;
          end else begin
            state_next = S_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_next = S_RESP;
        else             cnt_next   = cnt - 4'd1;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign enter_resp = (state_next == S_RESP) && (state != S_RESP);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      req_write <= 1'b0;
      req_err   <= 1'b0;
      req_idx   <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == S_IDLE && live_any) begin
        req_write <= bus.mem_write;
        req_err   <= live_err;
        req_idx   <= live_idx;
        req_wdata <= bus.wdata;
      end
      // Writes leave rdata untouched; errors return zero.
      if (enter_resp) begin
        if (cur_err)         rdata_q <= '0;
        else if (!cur_write) rdata_q <= mem[cur_idx];
      end
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents
  // across reset; the commit is gated by rst so a reset held over the
  // commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_write && !cur_err) begin
      mem[cur_idx] <= cur_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = (state == S_RESP);
  assign bus.err   = (state == S_RESP) && req_err;
  assign bus.busy  = (state != S_IDLE);

endmodule
